fft_out_reorder: RTL and testbench

//   Output stage of FFT_256. Collects the 256 complex results from the radix-2

---
 rtl/fft_out_reorder.sv | 89 ++++++++
 tb/tb_fft_out_reorder.sv | 132 +++++++++++++
 2 files changed

// File: rtl/fft_out_reorder.sv
// fft_out_reorder: turns the bit-reversed FFT core output back into natural order.
// Two RAM banks take turns: one is filled while the other is read.
module fft_out_reorder #(
    parameter int N     = 256,
    parameter int LOG2N = 8,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_yr,
    input  logic [DW-1:0] in_yi,
    output logic          out_valid,
    output logic [DW-1:0] out_yp_real,
    output logic [DW-1:0] out_yp_img
);
    typedef enum logic {IDLE, READ} state_t;

    state_t            state, state_nxt;
    logic [LOG2N-1:0]  wr_cnt, rd_cnt;
    logic              wr_bank, rd_bank;
    logic              start, rd_en, rd_v;
    logic [2*DW-1:0]   mem [2*N];
    logic [2*DW-1:0]   rd_data;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        for (int i = 0; i < LOG2N; i++) bitrev[i] = a[LOG2N-1-i];
    endfunction

    // start fires on the edge that accepts the last sample, so the reader
    // begins on that same edge and the first output lands two edges later
    assign start = in_valid && (&wr_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else if (in_valid) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (start) begin
                wr_bank <= ~wr_bank;
                rd_bank <= wr_bank;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid) mem[{wr_bank, bitrev(wr_cnt)}] <= {in_yr, in_yi};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = start ? READ : (state == READ && !(&rd_cnt)) ? READ : IDLE;
    end

    always_comb begin
        rd_en = (state == READ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rd_cnt <= '0;
        else if (start) rd_cnt <= '0;
        else if (rd_en) rd_cnt <= rd_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        rd_data <= mem[{rd_bank, rd_cnt}];
    end

    // outputs are forced to zero between bursts rather than held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v        <= 1'b0;
            out_valid   <= 1'b0;
            out_yp_real <= '0;
            out_yp_img  <= '0;
        end else begin
            rd_v        <= rd_en;
            out_valid   <= rd_v;
            out_yp_real <= rd_v ? rd_data[2*DW-1:DW] : '0;
            out_yp_img  <= rd_v ? rd_data[DW-1:0] : '0;
        end
    end
endmodule

// File: tb/tb_fft_out_reorder.sv
// tb_fft_out_reorder: directed frames checked against natural-order expectations.
module tb_fft_out_reorder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_yr = '0, in_yi = '0;
    logic        out_valid;
    logic [15:0] out_yp_real, out_yp_img;

    int          vectors = 0, miscompares = 0;
    logic [31:0] exp_q [$];
    int          bursts [$];
    int          run = 0;

    fft_out_reorder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_yr(in_yr), .in_yi(in_yi),
        .out_valid(out_valid), .out_yp_real(out_yp_real), .out_yp_img(out_yp_img)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] a);
        for (int i = 0; i < 8; i++) rev8[i] = a[7-i];
    endfunction

    // natural-order value of bin k: mode 0 = {k+off, -(k+off)}, mode 1 = extremes
    function automatic logic [31:0] val(input int k, input int off, input bit ext);
        logic [15:0] re;
        re = ext ? ((k % 2) ? 16'h7FFF : 16'h8000) : 16'(k + off);
        return ext ? {re, ~re} : {re, 16'(-re)};
    endfunction

    task automatic send(input int off, input bit ext, input bit gap, input int cnt, input bit push);
        logic [31:0] v;
        for (int c = 0; c < cnt; c++) begin
            v = val(int'(rev8(8'(c))), off, ext);
            @(negedge clk);
            in_valid = 1'b1;
            {in_yr, in_yi} = v;
            if (gap && c != cnt - 1) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
        end
        if (push) for (int k = 0; k < cnt; k++) exp_q.push_back(val(k, off, ext));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic expect_bursts(input string tag, input int n, input int len);
        chk({tag, "_nburst"}, 32'(bursts.size()), 32'(n));
        foreach (bursts[i]) chk({tag, "_len"}, 32'(bursts[i]), 32'(len));
        chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        bursts.delete();
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            run++;
            if (exp_q.size() == 0) chk("extra_out", {out_yp_real, out_yp_img}, 32'hXXXX_XXXX);
            else chk("data", {out_yp_real, out_yp_img}, exp_q.pop_front());
        end else begin
            chk("idle_zero", {out_yp_real, out_yp_img}, 32'd0);
            if (run > 0) bursts.push_back(run);
            run = 0;
        end
    end

    initial begin
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_out", {out_yp_real, out_yp_img}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        chk("post_rst_valid", 32'(out_valid), 32'd0);

        send(0, 1'b0, 1'b0, 256, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("lat_e1", 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("lat_e2", 32'(out_valid), 32'd1);
        idle(300);
        expect_bursts("single", 1, 256);

        send(0, 1'b0, 1'b0, 256, 1'b1);
        send(1000, 1'b0, 1'b0, 256, 1'b1);
        idle(300);
        expect_bursts("b2b", 1, 512);

        send(0, 1'b0, 1'b1, 256, 1'b1);
        idle(300);
        expect_bursts("gapped", 1, 256);

        send(500, 1'b0, 1'b0, 100, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(0, 1'b0, 1'b0, 256, 1'b1);
        idle(300);
        expect_bursts("midrst", 1, 256);

        send(0, 1'b1, 1'b0, 256, 1'b1);
        idle(300);
        expect_bursts("extreme", 1, 256);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
